// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Shares the init/done start-complete handshake with the shift-add multiplier.
// Optional feature: define DIV_ZERO_DETECT_EN to add the div_zero port and a
// one-cycle early exit when the captured divisor is zero.
module div_seq #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         init,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
`ifdef DIV_ZERO_DETECT_EN
  output logic         div_zero,
`endif
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N:0]      r_q, r_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            dz_q, dz_d;

  // Shifted {R,Q} and trial subtraction; T is one bit wider so its MSB is the sign.
  logic [2*N:0]    rq_sh;
  logic [N:0]      r_sh;
  logic [N-1:0]    q_sh;
  logic [N+1:0]    t;

  assign rq_sh = {r_q, q_q} << 1;
  assign r_sh  = rq_sh[2*N:N];
  assign q_sh  = rq_sh[N-1:0];
  assign t     = {1'b0, r_sh} - {2'b00, d_q};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = done_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (init) begin
          r_d    = '0;
          q_d    = a;
          d_d    = b;
          cnt_d  = CW'(N);
          done_d = 1'b0;
          busy_d = 1'b1;
          dz_d   = 1'b0;
          state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
          // Zero divisor: skip the iterations, return the values the loop would give.
          if (b == '0) begin
            quot_d  = '1;
            rem_d   = a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        // init is ignored here; the running division always completes.
        if (t[N+1]) begin
          r_d = r_sh;
          q_d = q_sh;
        end else begin
          r_d = t[N:0];
          q_d = q_sh | N'(1);
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quot_d  = q_d;
          rem_d   = r_d[N-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign done      = done_q;
  assign busy      = busy_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = dz_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at N=3; builds with or without DIV_ZERO_DETECT_EN.
module tb_div_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a, b;
  logic       init;
  logic [2:0] quotient, remainder;
  logic       done, busy;
`ifdef DIV_ZERO_DETECT_EN
  logic       div_zero;
`endif
  int tests = 0;
  int fails = 0;

  div_seq #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .init(init),
    .quotient(quotient), .remainder(remainder), .done(done),
`ifdef DIV_ZERO_DETECT_EN
    .div_zero(div_zero),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse init for one edge (E0); returns 1ns after E0.
  task automatic start(input logic [2:0] av, input logic [2:0] bv);
    a = av; b = bv; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  // Counts edges until done is seen, bounded to 20 cycles.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; init = 1'b1; a = 3'd7; b = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({quotient, remainder, done, busy} !== 8'b0) begin
      fails++;
      $display("FAIL reset: q=%0d r=%0d done=%b busy=%b, want 0 0 0 0", quotient, remainder, done, busy);
    end
    init = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    start(3'd7, 3'd2);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(lat);
    tests++;
    if (lat != 3 || quotient !== 3'd3 || remainder !== 3'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_7_2: lat=%0d q=%0d r=%0d busy=%b, want 3 3 1 0", lat, quotient, remainder, busy);
    end
  endtask

  task automatic test_edges;
    logic [2:0] va [3] = '{3'd5, 3'd7, 3'd0};
    logic [2:0] vb [3] = '{3'd7, 3'd1, 3'd3};
    logic [2:0] eq [3] = '{3'd0, 3'd7, 3'd0};
    logic [2:0] er [3] = '{3'd5, 3'd0, 3'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start(va[i], vb[i]);
      wait_done(lat);
      tests++;
      if (lat != 3 || quotient !== eq[i] || remainder !== er[i]) begin
        fails++;
        $display("FAIL edge_%0d_%0d: lat=%0d q=%0d r=%0d, want 3 %0d %0d",
                 va[i], vb[i], lat, quotient, remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_hold;
    int lat;
    int bad = 0;
    start(3'd6, 3'd3);
    wait_done(lat);
    tests++;
    if (quotient !== 3'd2 || remainder !== 3'd0) begin
      fails++;
      $display("FAIL hold_6_3: q=%0d r=%0d, want 2 0", quotient, remainder);
    end
    a = 3'd7; b = 3'd7;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (quotient !== 3'd2 || remainder !== 3'd0 || done !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_no_init: %0d cycles changed, want 0 (q=%0d r=%0d)", bad, quotient, remainder);
    end
    start(3'd7, 3'd7);
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_from_done: done=%b busy=%b, want 0 1", done, busy);
    end
    wait_done(lat);
    tests++;
    if (quotient !== 3'd1 || remainder !== 3'd0) begin
      fails++;
      $display("FAIL hold_7_7: q=%0d r=%0d, want 1 0", quotient, remainder);
    end
  endtask

  task automatic test_init_ignored;
    int lat;
    start(3'd6, 3'd4);
    a = 3'd7; b = 3'd1; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    wait_done(lat);
    tests++;
    if (lat != 2 || quotient !== 3'd1 || remainder !== 3'd2) begin
      fails++;
      $display("FAIL init_in_run: lat=%0d q=%0d r=%0d, want 2 1 2", lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start(3'd3, 3'd2);
    wait_done(lat);
    tests++;
    if (lat != 3 || quotient !== 3'd1 || remainder !== 3'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d busy=%b, want 3 1 1 0", lat, quotient, remainder, busy);
    end
    start(3'd6, 3'd5);
    wait_done(lat);
    tests++;
    if (lat != 3 || quotient !== 3'd1 || remainder !== 3'd1) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, want 3 1 1", lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    start(3'd7, 3'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({quotient, remainder, done, busy} !== 8'b0) begin
      fails++;
      $display("FAIL reset_mid: q=%0d r=%0d done=%b busy=%b, want 0 0 0 0", quotient, remainder, done, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    start(3'd5, 3'd0);
    wait_done(lat);
`ifdef DIV_ZERO_DETECT_EN
    tests++;
    if (lat != 0 || quotient !== 3'd7 || remainder !== 3'd5 || div_zero !== 1'b1) begin
      fails++;
      $display("FAIL dz_detect: lat=%0d q=%0d r=%0d dz=%b, want 0 7 5 1", lat, quotient, remainder, div_zero);
    end
    start(3'd4, 3'd2);
    wait_done(lat);
    tests++;
    if (lat != 3 || quotient !== 3'd2 || remainder !== 3'd0 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL dz_clear: lat=%0d q=%0d r=%0d dz=%b, want 3 2 0 0", lat, quotient, remainder, div_zero);
    end
`else
    tests++;
    if (lat != 3 || quotient !== 3'd7 || remainder !== 3'd5) begin
      fails++;
      $display("FAIL div_zero: lat=%0d q=%0d r=%0d, want 3 7 5", lat, quotient, remainder);
    end
`endif
  endtask

  // busy and done must never be high together.
  int both_hi = 0;
  always @(negedge clk) if (rst_n === 1'b1 && busy === 1'b1 && done === 1'b1) both_hi++;

  initial begin
    a = '0; b = '0; init = 1'b0; rst_n = 1'b0;
    test_reset;
    test_basic;
    test_edges;
    test_hold;
    test_init_ignored;
    test_back_to_back;
    test_div_zero;
    test_reset_mid;
    tests++;
    if (both_hi != 0) begin
      fails++;
      $display("FAIL busy_done_exclusive: %0d cycles both high, want 0", both_hi);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
